i2cm_sfifo_th: RTL and testbench

//  Parametrised sync FIFO, successor of the I2C master byte FIFO. Adds arbitrary

---
 rtl/i2cm_sfifo_th_pkg.sv | 15 +
 rtl/i2cm_sfifo_th_mem.sv | 28 ++
 rtl/i2cm_sfifo_th.sv | 145 ++++++++++++++
 tb/tb_i2cm_sfifo_th.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2cm_sfifo_th_pkg.sv
// Shared constants for the I2C master sync FIFO: default geometry and read-port modes.
package i2cm_sfifo_th_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_DEPTH = 16;

  typedef enum logic {
    RD_PORT_REG  = 1'b0,
    RD_PORT_FWFT = 1'b1
  } rdPortMode_e;

  localparam int DEF_FWFT = int'(RD_PORT_FWFT);

endpackage

// File: rtl/i2cm_sfifo_th_mem.sv
// FIFO storage: DATA_DEPTH x DATA_WIDTH registers, one synchronous write port, one async read port.
module i2cm_sfifo_th_mem
  import i2cm_sfifo_th_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
  input  logic                  sys_clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Storage is deliberately not reset; readers qualify it with the valid/empty state.
  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  always_ff @(posedge sys_clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2cm_sfifo_th.sv
// Parametrised sync FIFO between the APB register file and the I2C shift engine,
// with thresholds, sticky error flags and selectable FWFT or registered read port.
module i2cm_sfifo_th
  import i2cm_sfifo_th_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  en,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH:0]   afull_th,
  input  logic [ADDR_WIDTH:0]   aempty_th,
  input  logic                  flag_clr,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_vld,
  output logic [ADDR_WIDTH:0]   word_cnt,
  output logic [ADDR_WIDTH:0]   free_cnt,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_stk,
  output logic                  udf_stk
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ovf_stk_q, ovf_stk_d, udf_stk_q, udf_stk_d;
  logic                  wr, rd;
  logic [DATA_WIDTH-1:0] rdata;

  assign full      = (cnt_q == DEPTH_CNT);
  assign empty     = (cnt_q == '0);
  assign wr        = push & (~full | pop);
  assign rd        = pop & ~empty;
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;
  assign word_cnt  = cnt_q;
  assign free_cnt  = DEPTH_CNT - cnt_q;
  assign afull     = (cnt_q >= afull_th);
  assign aempty    = (cnt_q <= aempty_th);
  assign ovf_stk   = ovf_stk_q;
  assign udf_stk   = udf_stk_q;

  // Pointers wrap explicitly at DATA_DEPTH-1 so non-power-of-2 depths work.
  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    ovf_stk_d = overflow ? 1'b1 : (flag_clr ? 1'b0 : ovf_stk_q);
    udf_stk_d = underflow ? 1'b1 : (flag_clr ? 1'b0 : udf_stk_q);
    if (wr) begin
      wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
    end
    if (rd) begin
      rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
    end
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (!en) begin
      wp_d      = '0;
      rp_d      = '0;
      cnt_d     = '0;
      ovf_stk_d = 1'b0;
      udf_stk_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_stk_q <= 1'b0;
      udf_stk_q <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_stk_q <= ovf_stk_d;
      udf_stk_q <= udf_stk_d;
    end
  end

  i2cm_sfifo_th_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_mem (
    .sys_clk (sys_clk),
    .we_i    (wr & en),
    .waddr_i (wp_q),
    .wdata_i (data_i),
    .raddr_i (rp_q),
    .rdata_o (rdata)
  );

  generate
    if (FWFT == int'(RD_PORT_FWFT)) begin : g_fwft
      assign data_o   = rdata;
      assign data_vld = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  vld_q, vld_d;

      // A soft reset also swallows a pop issued in the same cycle.
      always_comb begin
        data_d = rd ? rdata : data_q;
        vld_d  = rd;
        if (!en) begin
          data_d = '0;
          vld_d  = 1'b0;
        end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          vld_q  <= vld_d;
        end
      end

      assign data_o   = data_q;
      assign data_vld = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_i2cm_sfifo_th.sv
// Self-checking bench: a depth-6 FWFT instance driven from a vector table and a
// depth-16 registered-read instance checked by hand sequences and a queue model.
module tb_i2cm_sfifo_th;

  logic sysClk = 1'b0;
  logic sysRst;
  always #5 sysClk = ~sysClk;

  int checks = 0;
  int errors = 0;

  // Instance A: depth 6, first-word-fall-through
  logic       aEn, aPush, aPop, aFlagClr;
  logic [7:0] aData, aDataO;
  logic [4:0] aAfullTh, aAemptyTh, aCnt, aFree;
  logic       aVld, aFull, aEmpty, aAfull, aAempty, aOvf, aUdf, aOvfStk, aUdfStk;

  // Instance B: depth 16, registered read port
  logic       bEn, bPush, bPop, bFlagClr;
  logic [7:0] bData, bDataO;
  logic [4:0] bAfullTh, bAemptyTh, bCnt, bFree;
  logic       bVld, bFull, bEmpty, bAfull, bAempty, bOvf, bUdf, bOvfStk, bUdfStk;

  i2cm_sfifo_th #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DATA_DEPTH(6), .FWFT(1)) uA (
    .sys_clk(sysClk), .sys_rst(sysRst), .en(aEn), .push(aPush), .pop(aPop),
    .data_i(aData), .afull_th(aAfullTh), .aempty_th(aAemptyTh), .flag_clr(aFlagClr),
    .data_o(aDataO), .data_vld(aVld), .word_cnt(aCnt), .free_cnt(aFree),
    .full(aFull), .empty(aEmpty), .afull(aAfull), .aempty(aAempty),
    .overflow(aOvf), .underflow(aUdf), .ovf_stk(aOvfStk), .udf_stk(aUdfStk)
  );

  i2cm_sfifo_th #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DATA_DEPTH(16), .FWFT(0)) uB (
    .sys_clk(sysClk), .sys_rst(sysRst), .en(bEn), .push(bPush), .pop(bPop),
    .data_i(bData), .afull_th(bAfullTh), .aempty_th(bAemptyTh), .flag_clr(bFlagClr),
    .data_o(bDataO), .data_vld(bVld), .word_cnt(bCnt), .free_cnt(bFree),
    .full(bFull), .empty(bEmpty), .afull(bAfull), .aempty(bAempty),
    .overflow(bOvf), .underflow(bUdf), .ovf_stk(bOvfStk), .udf_stk(bUdfStk)
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic       chkHead;
    logic [7:0] head;
    logic       ovf;
    logic       udf;
    int         cnt;
    logic       full;
  } vec_t;

  vec_t vecs[17];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic po, input logic [7:0] d, input logic c);
    bPush    = p;
    bPop     = po;
    bData    = d;
    bFlagClr = c;
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  logic [7:0] q[$];
  logic [7:0] expData;
  logic       expVld, expOvfStk, expUdfStk, expOvf, expUdf;
  int         sz, pushPct;

  initial begin
    // Depth-6 table: fill, overflow, push+pop at full, drain across the wrap, empty corners
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h13, 1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h14, 1'b0, 8'h00, 1'b0, 1'b0, 4, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h15, 1'b0, 8'h00, 1'b0, 1'b0, 5, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h16, 1'b0, 8'h00, 1'b0, 1'b0, 6, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h77, 1'b1, 8'h11, 1'b1, 1'b0, 6, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h11, 1'b0, 1'b0, 6, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h13, 1'b0, 1'b0, 4, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h14, 1'b0, 1'b0, 3, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h15, 1'b0, 1'b0, 2, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h16, 1'b0, 1'b0, 1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 0, 1'b0};

    aEn = 1'b1; aPush = 1'b0; aPop = 1'b0; aFlagClr = 1'b0; aData = 8'h00;
    aAfullTh = 5'd5; aAemptyTh = 5'd1;
    bEn = 1'b1; bAfullTh = 5'd12; bAemptyTh = 5'd2;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset
    sysRst = 1'b1;
    repeat (2) @(posedge sysClk);
    #1;
    sysRst = 1'b0;
    #1;
    checkOutput("rst B empty", bEmpty, 1);
    checkOutput("rst B full", bFull, 0);
    checkOutput("rst B free_cnt", bFree, 16);
    checkOutput("rst B word_cnt", bCnt, 0);
    checkOutput("rst B data_vld", bVld, 0);
    checkOutput("rst B data_o", bDataO, 0);
    checkOutput("rst B ovf_stk", bOvfStk, 0);
    checkOutput("rst B udf_stk", bUdfStk, 0);
    checkOutput("rst A free_cnt", aFree, 6);
    checkOutput("rst A data_vld", aVld, 0);
    tick();

    // Table-driven depth-6 sequence
    for (int i = 0; i < 17; i++) begin
      aPush = vecs[i].push;
      aPop  = vecs[i].pop;
      aData = vecs[i].din;
      #1;
      if (vecs[i].chkHead) checkOutput($sformatf("A vec%0d head", i), aDataO, vecs[i].head);
      checkOutput($sformatf("A vec%0d overflow", i), aOvf, vecs[i].ovf);
      checkOutput($sformatf("A vec%0d underflow", i), aUdf, vecs[i].udf);
      tick();
      aPush = 1'b0;
      aPop  = 1'b0;
      checkOutput($sformatf("A vec%0d word_cnt", i), aCnt, vecs[i].cnt);
      checkOutput($sformatf("A vec%0d full", i), aFull, vecs[i].full);
      checkOutput($sformatf("A vec%0d free_cnt", i), aFree, 6 - vecs[i].cnt);
    end
    checkOutput("A ovf_stk held", aOvfStk, 1);
    checkOutput("A udf_stk held", aUdfStk, 1);
    checkOutput("A data_vld empty", aVld, 0);

    // Sticky clear, then clear colliding with a fresh underflow
    aFlagClr = 1'b1;
    tick();
    checkOutput("A ovf_stk cleared", aOvfStk, 0);
    checkOutput("A udf_stk cleared", aUdfStk, 0);
    aPop = 1'b1;
    #1;
    checkOutput("A underflow with clr", aUdf, 1);
    tick();
    aPop = 1'b0;
    aFlagClr = 1'b0;
    checkOutput("A udf_stk set wins", aUdfStk, 1);
    checkOutput("A ovf_stk stays 0", aOvfStk, 0);

    // Thresholds on depth 16: afull rises on the 12th word, aempty at 2
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      tick();
      checkOutput($sformatf("B fill%0d afull", i), bAfull, int'(i >= 12));
      checkOutput($sformatf("B fill%0d aempty", i), bAempty, int'(i <= 2));
    end
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
      tick();
      checkOutput($sformatf("B drain%0d data_o", i), bDataO, 8'h40 + i);
      checkOutput($sformatf("B drain%0d data_vld", i), bVld, 1);
      checkOutput($sformatf("B drain%0d aempty", i), bAempty, int'((12 - i) <= 2));
      checkOutput($sformatf("B drain%0d afull", i), bAfull, 0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("B idle data_vld", bVld, 0);
    checkOutput("B idle data_o hold", bDataO, 8'h4A);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    // Registered read latency
    applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    #1;
    checkOutput("B pre-pop data_vld", bVld, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("B 3C data_o", bDataO, 8'h3C);
    checkOutput("B 3C data_vld", bVld, 1);
    tick();
    checkOutput("B 3C vld one cycle", bVld, 0);

    // Soft reset mid-burst swallows the pending pop
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    bEn = 1'b0;
    tick();
    checkOutput("B en0 word_cnt", bCnt, 0);
    checkOutput("B en0 empty", bEmpty, 1);
    checkOutput("B en0 data_vld", bVld, 0);
    checkOutput("B en0 data_o", bDataO, 0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    bEn = 1'b1;
    tick();

    // Randomized traffic against a queue model
    expData = 8'h00; expVld = 1'b0; expOvfStk = 1'b0; expUdfStk = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc % 50 == 0) begin
        bAfullTh  = 5'($urandom_range(0, 18));
        bAemptyTh = 5'($urandom_range(0, 17));
      end
      pushPct = ((cyc / 100) % 2 == 0) ? 85 : 20;
      applyStimulus(1'($urandom_range(0, 99) < pushPct),
                    1'($urandom_range(0, 99) >= pushPct),
                    8'($urandom), 1'($urandom_range(0, 7) == 0));
      #1;
      sz = q.size();
      expOvf = bPush && (sz == 16) && !bPop;
      expUdf = bPop && (sz == 0);
      checkOutput("R word_cnt", bCnt, sz);
      checkOutput("R free_cnt", bFree, 16 - sz);
      checkOutput("R full", bFull, int'(sz == 16));
      checkOutput("R empty", bEmpty, int'(sz == 0));
      checkOutput("R afull", bAfull, int'(sz >= int'(bAfullTh)));
      checkOutput("R aempty", bAempty, int'(sz <= int'(bAemptyTh)));
      checkOutput("R overflow", bOvf, expOvf);
      checkOutput("R underflow", bUdf, expUdf);
      expVld = 1'b0;
      if (bPop && sz > 0) begin
        expData = q.pop_front();
        expVld  = 1'b1;
      end
      if (bPush && (sz < 16 || bPop)) q.push_back(bData);
      expOvfStk = expOvf ? 1'b1 : (bFlagClr ? 1'b0 : expOvfStk);
      expUdfStk = expUdf ? 1'b1 : (bFlagClr ? 1'b0 : expUdfStk);
      tick();
      checkOutput("R data_vld", bVld, expVld);
      checkOutput("R data_o", bDataO, expData);
      checkOutput("R ovf_stk", bOvfStk, expOvfStk);
      checkOutput("R udf_stk", bUdfStk, expUdfStk);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
